// File: rtl/ifetch_ir.sv
// Instruction fetch and instruction register: fixed-latency memory read,
// latched instruction word, field slices and a sign-extended immediate.
module ifetch_ir #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FETCH_REQ,
  input  logic [63:0] PC_IN,
  output logic [63:0] MEM_ADDR,
  output logic        MEM_RD,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] IR31_0,
  output logic [6:0]  IR6_0,
  output logic [4:0]  IR11_7,
  output logic [2:0]  IR14_12,
  output logic [4:0]  IR19_15,
  output logic [4:0]  IR24_20,
  output logic [6:0]  IR31_25,
  output logic [63:0] IMM,
  output logic        INSTR_VALID,
  output logic        BUSY,
  output logic        FETCH_ERR
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned WORD_W = 32;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                mem_rd_nxt;
  logic [WORD_W-1:0]   ir_nxt;
  logic [63:0]         imm_nxt;
  logic                valid_nxt;
  logic                busy_nxt;
  logic                err_nxt;
  logic                aligned_c;

  // Immediate decode straight from the incoming memory word.
  function automatic logic [63:0] imm_of(input logic [WORD_W-1:0] w);
    logic [63:0] r;
    r = 64'd0;
    case (w[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR:
        r = {{52{w[31]}}, w[31:20]};
      OP_STORE:
        r = {{52{w[31]}}, w[31:25], w[11:7]};
      OP_BRANCH:
        r = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        r = {{32{w[31]}}, w[31:12], 12'b0};
      OP_JAL:
        r = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:
        r = 64'd0;
    endcase
    return r;
  endfunction

  assign aligned_c = (PC_IN[1:0] == 2'b00);

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      MEM_ADDR    <= '0;
      MEM_RD      <= 1'b0;
      IR31_0      <= '0;
      IMM         <= '0;
      INSTR_VALID <= 1'b0;
      BUSY        <= 1'b0;
      FETCH_ERR   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      MEM_ADDR    <= addr_nxt;
      MEM_RD      <= mem_rd_nxt;
      IR31_0      <= ir_nxt;
      IMM         <= imm_nxt;
      INSTR_VALID <= valid_nxt;
      BUSY        <= busy_nxt;
      FETCH_ERR   <= err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = MEM_ADDR;
    mem_rd_nxt = MEM_RD;
    ir_nxt     = IR31_0;
    imm_nxt    = IMM;
    valid_nxt  = INSTR_VALID;
    busy_nxt   = BUSY;
    err_nxt    = FETCH_ERR;

    case (state)
      IDLE, HOLD, ERR: begin
        if (FETCH_REQ) begin
          if (aligned_c) begin
            state_nxt  = WAIT;
            cnt_nxt    = CNT_LOAD;
            addr_nxt   = PC_IN;
            mem_rd_nxt = 1'b1;
            busy_nxt   = 1'b1;
            valid_nxt  = 1'b0;
            err_nxt    = 1'b0;
          end else begin
            state_nxt  = ERR;
            mem_rd_nxt = 1'b0;
            busy_nxt   = 1'b0;
            valid_nxt  = 1'b0;
            err_nxt    = 1'b1;
          end
        end
      end
      WAIT: begin
        // Requests are ignored until the word has been captured.
        if (cnt == '0) begin
          state_nxt  = HOLD;
          ir_nxt     = MEM_RDATA;
          imm_nxt    = imm_of(MEM_RDATA);
          mem_rd_nxt = 1'b0;
          busy_nxt   = 1'b0;
          valid_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign IR6_0   = IR31_0[6:0];
  assign IR11_7  = IR31_0[11:7];
  assign IR14_12 = IR31_0[14:12];
  assign IR19_15 = IR31_0[19:15];
  assign IR24_20 = IR31_0[24:20];
  assign IR31_25 = IR31_0[31:25];

endmodule

// File: tb/tb_ifetch_ir.sv
// Self-checking bench for ifetch_ir: directed spec cases, misaligned and
// reset-abort scenarios, and randomized fetches against an arithmetic model.
module tb_ifetch_ir;

  localparam int unsigned L = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FETCH_REQ;
  logic [63:0] PC_IN;
  logic [63:0] MEM_ADDR;
  logic        MEM_RD;
  logic [31:0] MEM_RDATA;
  logic [31:0] IR31_0;
  logic [6:0]  IR6_0;
  logic [4:0]  IR11_7;
  logic [2:0]  IR14_12;
  logic [4:0]  IR19_15;
  logic [4:0]  IR24_20;
  logic [6:0]  IR31_25;
  logic [63:0] IMM;
  logic        INSTR_VALID;
  logic        BUSY;
  logic        FETCH_ERR;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] cur_word = 32'd0;
  int          rd_age = 0;
  int          valid_rises = 0;
  logic        prev_valid = 1'b0;

  ifetch_ir #(.MEM_LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET), .FETCH_REQ(FETCH_REQ), .PC_IN(PC_IN),
    .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_RDATA(MEM_RDATA),
    .IR31_0(IR31_0), .IR6_0(IR6_0), .IR11_7(IR11_7), .IR14_12(IR14_12),
    .IR19_15(IR19_15), .IR24_20(IR24_20), .IR31_25(IR31_25), .IMM(IMM),
    .INSTR_VALID(INSTR_VALID), .BUSY(BUSY), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  // Memory model: data only valid in the last read cycle, garbage otherwise.
  always @(posedge CLK) begin
    rd_age      <= (MEM_RD === 1'b1) ? rd_age + 1 : 0;
    prev_valid  <= INSTR_VALID;
    if (INSTR_VALID === 1'b1 && prev_valid !== 1'b1) valid_rises <= valid_rises + 1;
  end

  always @(negedge CLK) begin
    if (MEM_RD === 1'b1 && rd_age == int'(L) - 1) MEM_RDATA = cur_word;
    else MEM_RDATA = $urandom;
  end

  // Reference immediate: arithmetic on a sign-extended copy of the word.
  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint sw;
    longint u;
    sw = longint'($signed(w));
    u  = longint'(w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67: return sw >>> 20;
      7'h23: return ((sw >>> 25) <<< 5) | ((u >> 7) & 31);
      7'h63: return ((sw >>> 31) <<< 12) | (((u >> 7) & 1) << 11)
                  | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      7'h37, 7'h17: return sw & ~longint'(4095);
      7'h6F: return ((sw >>> 31) <<< 20) | (((u >> 12) & 255) << 12)
                  | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      default: return 64'd0;
    endcase
  endfunction

  // Issues a request in the current cycle and returns at the first valid cycle.
  task automatic do_fetch(input logic [63:0] pc, input logic [31:0] word,
                          output int lat, output int rd_cnt, output bit addr_ok);
    cur_word  = word;
    PC_IN     = pc;
    FETCH_REQ = 1'b1;
    @(negedge CLK);
    FETCH_REQ = 1'b0;
    PC_IN     = {$urandom, $urandom};
    lat = 1; rd_cnt = 0; addr_ok = 1'b1;
    while (INSTR_VALID !== 1'b1 && lat < 40) begin
      if (MEM_RD === 1'b1) begin
        rd_cnt++;
        if (MEM_ADDR !== pc) addr_ok = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; FETCH_REQ = 1'b0; PC_IN = '0;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({MEM_ADDR, MEM_RD, IR31_0, IMM, INSTR_VALID, BUSY, FETCH_ERR} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: addr=%h rd=%b ir=%h imm=%h v=%b b=%b e=%b required all zero",
               MEM_ADDR, MEM_RD, IR31_0, IMM, INSTR_VALID, BUSY, FETCH_ERR);
    end
    vectors++;
    if ({IR31_25, IR24_20, IR19_15, IR14_12, IR11_7, IR6_0} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_fields: got %h required 0",
               {IR31_25, IR24_20, IR19_15, IR14_12, IR11_7, IR6_0});
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    logic [63:0] pcs  [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
    logic [31:0] wds  [4] = '{32'h00500093, 32'h0020B423, 32'hFE000EE3, 32'h123452B7};
    logic [63:0] imms [4] = '{64'd5, 64'd8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_1234_5000};
    int lat, rdc; bit aok;
    for (int i = 0; i < 4; i++) begin
      do_fetch(pcs[i], wds[i], lat, rdc, aok);
      vectors++;
      if (lat != int'(L) + 1 || rdc != int'(L) || !aok) begin
        miscompares++;
        $display("FAIL dir_timing[%0d]: lat=%0d rd_cycles=%0d addr_ok=%0d required %0d %0d 1",
                 i, lat, rdc, aok, L + 1, L);
      end
      vectors++;
      if (IR31_0 !== wds[i] || IMM !== imms[i]) begin
        miscompares++;
        $display("FAIL dir_value[%0d]: ir=%h imm=%h required ir=%h imm=%h",
                 i, IR31_0, IMM, wds[i], imms[i]);
      end
      vectors++;
      if ({IR31_25, IR24_20, IR19_15, IR14_12, IR11_7, IR6_0} !== wds[i] || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL dir_fields[%0d]: fields=%h busy=%b required %h 0", i,
                 {IR31_25, IR24_20, IR19_15, IR14_12, IR11_7, IR6_0}, BUSY, wds[i]);
      end
    end
    vectors++;
    if (IR6_0 !== 7'b0110111 || IR11_7 !== 5'd5) begin
      miscompares++;
      $display("FAIL lui_fields: op=%b rd=%0d required 0110111 5", IR6_0, IR11_7);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] prev_ir;
    bit rd_seen;
    int lat, rdc; bit aok;
    prev_ir = IR31_0;
    rd_seen = 1'b0;
    PC_IN = 64'h6; FETCH_REQ = 1'b1;
    @(negedge CLK);
    FETCH_REQ = 1'b0;
    vectors++;
    if (FETCH_ERR !== 1'b1 || INSTR_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_err: err=%b valid=%b required 1 0", FETCH_ERR, INSTR_VALID);
    end
    for (int c = 0; c < 4; c++) begin
      if (MEM_RD !== 1'b0) rd_seen = 1'b1;
      if (c == 1) begin PC_IN = 64'h3; FETCH_REQ = 1'b1; end
      else FETCH_REQ = 1'b0;
      @(negedge CLK);
    end
    vectors++;
    if (rd_seen || FETCH_ERR !== 1'b1 || IR31_0 !== prev_ir) begin
      miscompares++;
      $display("FAIL misalign_hold: rd_seen=%0d err=%b ir=%h required 0 1 %h",
               rd_seen, FETCH_ERR, IR31_0, prev_ir);
    end
    do_fetch(64'h8, 32'h00A00113, lat, rdc, aok);
    vectors++;
    if (lat != int'(L) + 1 || FETCH_ERR !== 1'b0 || IR31_0 !== 32'h00A00113 || IMM !== 64'd10) begin
      miscompares++;
      $display("FAIL misalign_recover: lat=%0d err=%b ir=%h imm=%h required %0d 0 00a00113 a",
               lat, FETCH_ERR, IR31_0, IMM, L + 1);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] w;
    int rises0;
    bit addr_ok;
    int rdc;
    cur_word = 32'h02A00193;
    PC_IN = 64'h10; FETCH_REQ = 1'b1;
    @(negedge CLK);
    FETCH_REQ = 1'b0;
    @(negedge CLK);
    vectors++;
    if (MEM_RD !== 1'b1 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_state: rd=%b busy=%b required 1 1", MEM_RD, BUSY);
    end
    #1 RESET = 1'b1;
    #1;
    vectors++;
    if ({MEM_ADDR, MEM_RD, IR31_0, IMM, INSTR_VALID, BUSY, FETCH_ERR} !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: addr=%h rd=%b ir=%h imm=%h v=%b b=%b e=%b required all zero",
               MEM_ADDR, MEM_RD, IR31_0, IMM, INSTR_VALID, BUSY, FETCH_ERR);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    w = 32'hFFF00293;
    cur_word = w;
    rises0 = valid_rises;
    PC_IN = 64'h20; FETCH_REQ = 1'b1;
    @(negedge CLK);
    PC_IN = 64'h40;
    rdc = 0; addr_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      FETCH_REQ = (c == 0);
      if (MEM_RD === 1'b1) begin
        rdc++;
        if (MEM_ADDR !== 64'h20) addr_ok = 1'b0;
      end
      @(negedge CLK);
    end
    vectors++;
    if (valid_rises - rises0 != 1 || rdc != int'(L) || !addr_ok || IR31_0 !== w
        || IMM !== 64'hFFFF_FFFF_FFFF_FFFF || INSTR_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_wait_req: captures=%0d rd_cycles=%0d addr_ok=%0d ir=%h imm=%h v=%b required 1 %0d 1 %h ffffffffffffffff 1",
               valid_rises - rises0, rdc, addr_ok, IR31_0, IMM, INSTR_VALID, L, w);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    logic [31:0] r, w;
    logic [63:0] pc, exp_imm;
    int lat, rdc; bit aok;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom;
      w  = {r[31:7], ops[$urandom_range(9)]};
      if (i % 8 == 7) begin r = $urandom; w = r; end
      pc = {$urandom, $urandom} & ~64'h3;
      exp_imm = ref_imm(w);
      do_fetch(pc, w, lat, rdc, aok);
      vectors++;
      if (lat != int'(L) + 1 || rdc != int'(L) || !aok || IR31_0 !== w || IMM !== exp_imm) begin
        miscompares++;
        $display("FAIL random[%0d]: lat=%0d rd=%0d addr_ok=%0d ir=%h imm=%h required %0d %0d 1 %h %h",
                 i, lat, rdc, aok, IR31_0, IMM, L + 1, L, w, exp_imm);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    time t_prev;
    int lat, rdc; bit aok;
    t_prev = $time;
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      do_fetch(64'(i * 4), r, lat, rdc, aok);
      vectors++;
      if (($time - t_prev) != time'((L + 1) * 10) || IR31_0 !== r) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: period=%0t ir=%h required %0d %h",
                 i, $time - t_prev, IR31_0, (L + 1) * 10, r);
      end
      t_prev = $time;
    end
  endtask

  initial begin
    FETCH_REQ = 1'b0;
    PC_IN     = '0;
    RESET     = 1'b1;
    test_reset();
    test_directed();
    test_misaligned();
    test_reset_mid_fetch();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
